// File: rtl/gt_link_pkg.sv
// Symbols and state encoding shared by the GT TX framer and the future RX deframer.
package gt_link_pkg;

  localparam logic [7:0] K_IDLE     = 8'hBC;
  localparam logic [7:0] K_SOF      = 8'hFB;
  localparam logic [7:0] K_EOF      = 8'hFD;
  localparam logic [3:0] CHARISK_K0 = 4'b0001;

  typedef enum logic [2:0] {
    ST_ALIGN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SOF   = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_EOF   = 3'd5,
    ST_DROP  = 3'd6
  } framer_state_t;

  function automatic logic [31:0] k_word(input logic [7:0] k);
    return {24'h000000, k};
  endfunction

endpackage

// File: rtl/gt_tx_framer.sv
// Frames a 32-bit valid/ready stream into a K28.5-idled 8b/10b word stream for the GT.
// Define GT_TX_FRAMER_CHECKSUM_EN to append a modulo-2^32 payload sum before EOF.
//
// state | meaning
// ALIGN | post-reset comma preamble
// IDLE  | commas between frames, enforcing the inter-frame gap
// SOF   | start-of-frame marker
// DATA  | payload beats, idle filler when upstream stalls
// CSUM  | checksum word (checksum build only)
// EOF   | end-of-frame marker
// DROP  | discard the tail of a frame cut at MAX_LEN
module gt_tx_framer
  import gt_link_pkg::*;
#(
  parameter int MAX_LEN     = 1024,
  parameter int MIN_IFG     = 4,
  parameter int ALIGN_IDLES = 200
) (
  input  logic        tx_usr_clk,
  input  logic        gt_reset_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_charisk,
  output logic [15:0] frame_cnt,
  output logic        err_overlen,
  output logic        busy
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(MIN_IFG + 1);
  // The reset word and the idles leaving IDLE and SOF also count toward the preamble.
  localparam int ALIGN_LOAD = (ALIGN_IDLES > 3) ? ALIGN_IDLES - 3 : 0;
  localparam int ALIGN_W    = (ALIGN_LOAD > 0) ? $clog2(ALIGN_LOAD + 1) : 1;

  localparam logic [31:0] WORD_IDLE = k_word(K_IDLE);
  localparam logic [31:0] WORD_SOF  = k_word(K_SOF);
  localparam logic [31:0] WORD_EOF  = k_word(K_EOF);

  framer_state_t      state, state_nxt;
  logic [ALIGN_W-1:0] align_cnt;
  logic [GAP_W-1:0]   gap_cnt, gap_seen;
  logic [LEN_W-1:0]   len_cnt;
  logic               truncated;
  logic               accept, beat_last, beat_overlen, gap_met;
  logic [31:0]        tx_data_d;
  logic [3:0]         tx_charisk_d;
  logic [15:0]        frame_cnt_d;
  logic               err_overlen_d;
`ifdef GT_TX_FRAMER_CHECKSUM_EN
  logic [31:0]        csum;
`endif

  assign s_ready      = (state == ST_DATA) || (state == ST_DROP);
  assign accept       = s_ready & s_valid;
  assign beat_last    = accept & s_last;
  assign beat_overlen = (state == ST_DATA) & accept & ~s_last &
                        (len_cnt == LEN_W'(MAX_LEN - 1));
  // gap_seen includes the idle word leaving this cycle.
  assign gap_seen = (gap_cnt == GAP_W'(MIN_IFG)) ? gap_cnt : gap_cnt + GAP_W'(1);
  assign gap_met  = (gap_seen == GAP_W'(MIN_IFG));

  always_ff @(posedge tx_usr_clk or posedge gt_reset_n) begin
    if (gt_reset_n) state <= ST_ALIGN;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ALIGN: if (align_cnt == '0) state_nxt = ST_IDLE;
      ST_IDLE:  if (s_valid && gap_met) state_nxt = ST_SOF;
      ST_SOF:   state_nxt = ST_DATA;
      ST_DATA: begin
        if (beat_last || beat_overlen) begin
`ifdef GT_TX_FRAMER_CHECKSUM_EN
          state_nxt = ST_CSUM;
`else
          state_nxt = ST_EOF;
`endif
        end
      end
`ifdef GT_TX_FRAMER_CHECKSUM_EN
      ST_CSUM:  state_nxt = ST_EOF;
`endif
      ST_EOF:   state_nxt = truncated ? ST_DROP : ST_IDLE;
      ST_DROP:  if (beat_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_ALIGN;
    endcase
  end

  always_comb begin
    tx_data_d     = WORD_IDLE;
    tx_charisk_d  = CHARISK_K0;
    frame_cnt_d   = frame_cnt;
    err_overlen_d = beat_overlen;
    unique case (state)
      ST_SOF: tx_data_d = WORD_SOF;
      ST_DATA: begin
        if (accept) begin
          tx_data_d    = s_data;
          tx_charisk_d = 4'b0000;
        end
      end
`ifdef GT_TX_FRAMER_CHECKSUM_EN
      ST_CSUM: begin
        tx_data_d    = csum;
        tx_charisk_d = 4'b0000;
      end
`endif
      ST_EOF: begin
        tx_data_d   = WORD_EOF;
        frame_cnt_d = frame_cnt + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tx_usr_clk or posedge gt_reset_n) begin
    if (gt_reset_n) begin
      tx_data     <= WORD_IDLE;
      tx_charisk  <= CHARISK_K0;
      frame_cnt   <= 16'd0;
      err_overlen <= 1'b0;
      busy        <= 1'b1;
    end else begin
      tx_data     <= tx_data_d;
      tx_charisk  <= tx_charisk_d;
      frame_cnt   <= frame_cnt_d;
      err_overlen <= err_overlen_d;
      busy        <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge tx_usr_clk or posedge gt_reset_n) begin
    if (gt_reset_n) begin
      align_cnt <= ALIGN_W'(ALIGN_LOAD);
      gap_cnt   <= GAP_W'(MIN_IFG);
      len_cnt   <= '0;
      truncated <= 1'b0;
`ifdef GT_TX_FRAMER_CHECKSUM_EN
      csum      <= 32'd0;
`endif
    end else begin
      if (state == ST_ALIGN && align_cnt != '0) align_cnt <= align_cnt - ALIGN_W'(1);
      unique case (state)
        ST_EOF:           gap_cnt <= '0;
        ST_IDLE, ST_DROP: gap_cnt <= gap_seen;
        default: ;
      endcase
      if (state == ST_SOF) begin
        len_cnt   <= '0;
        truncated <= 1'b0;
`ifdef GT_TX_FRAMER_CHECKSUM_EN
        csum      <= 32'd0;
`endif
      end else if (state == ST_DATA && accept) begin
        len_cnt <= len_cnt + LEN_W'(1);
`ifdef GT_TX_FRAMER_CHECKSUM_EN
        csum    <= csum + s_data;
`endif
      end
      if (beat_overlen) truncated <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gt_tx_framer.sv
// Randomised bench for gt_tx_framer: frame-level reference model compared against the symbol stream.
module tb_gt_tx_framer;
  import gt_link_pkg::*;

  localparam int MAX_LEN     = 8;
  localparam int MIN_IFG     = 4;
  localparam int ALIGN_IDLES = 200;
  localparam logic [31:0] W_IDLE = 32'h000000BC;
  localparam logic [31:0] W_SOF  = 32'h000000FB;
  localparam logic [31:0] W_EOF  = 32'h000000FD;

  logic        tx_usr_clk = 1'b0;
  logic        gt_reset_n = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] tx_data;
  logic [3:0]  tx_charisk;
  logic [15:0] frame_cnt;
  logic        err_overlen;
  logic        busy;

  gt_tx_framer #(.MAX_LEN(MAX_LEN), .MIN_IFG(MIN_IFG), .ALIGN_IDLES(ALIGN_IDLES)) dut (
    .tx_usr_clk (tx_usr_clk),
    .gt_reset_n (gt_reset_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .tx_data    (tx_data),
    .tx_charisk (tx_charisk),
    .frame_cnt  (frame_cnt),
    .err_overlen(err_overlen),
    .busy       (busy)
  );

  always #5 tx_usr_clk = ~tx_usr_clk;

  typedef struct {logic [31:0] data; logic [3:0] k; logic err;} sym_t;
  typedef struct {logic [31:0] data; logic last;} beat_t;

  sym_t  exp_q[$];
  beat_t beat_q[$];
  bit    vpat[$];
  int    n_cmp = 0, n_mis = 0;
  logic [15:0] exp_frames;
  int    word_no, idle_run, fill_cnt, pay_seen, exp_fill, valid_pct;
  bit    hold, seen_eof, in_frame, exact_gap, first_sof_pending;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h (word %0d)", tag, got, exp, word_no);
    end
  endtask

  // Reference: every offered beat is eventually accepted, so the symbol sequence is fixed per frame.
  task automatic add_frame(input int len, input bit ramp);
    logic [31:0] d, sum;
    int sent;
    sum  = '0;
    sent = (len > MAX_LEN) ? MAX_LEN : len;
    exp_q.push_back('{W_SOF, 4'b0001, 1'b0});
    for (int i = 0; i < len; i++) begin
      d = ramp ? 32'(i + 1) : $urandom;
      beat_q.push_back('{d, (i == len - 1)});
      if (i < sent) begin
        exp_q.push_back('{d, 4'b0000, (len > MAX_LEN) && (i == sent - 1)});
        sum = sum + d;
      end
    end
`ifdef GT_TX_FRAMER_CHECKSUM_EN
    exp_q.push_back('{sum, 4'b0000, 1'b0});
`endif
    exp_q.push_back('{W_EOF, 4'b0001, 1'b0});
  endtask

  task automatic monitor();
    sym_t s;
    bit is_idle;
    is_idle = (tx_data == W_IDLE) && (tx_charisk == 4'b0001);
    if (word_no <= ALIGN_IDLES) begin
      check("align_word", {tx_charisk, tx_data}, {4'b0001, W_IDLE});
      check("align_ready", s_ready, 0);
    end
    if (is_idle) begin
      check("err_overlen_idle", err_overlen, 0);
      idle_run++;
      if (in_frame) fill_cnt++;
    end else if (exp_q.size() == 0) begin
      check("unexpected_word", {tx_charisk, tx_data}, {4'b0001, W_IDLE});
    end else begin
      s = exp_q.pop_front();
      check("symbol", {tx_charisk, tx_data}, {s.k, s.data});
      check("err_overlen", err_overlen, s.err);
      if (s.k == 4'b0001 && s.data == W_SOF) begin
        if (seen_eof) begin
          check("ifg_min", idle_run >= MIN_IFG, 1);
          if (exact_gap) check("ifg_exact", idle_run, MIN_IFG);
        end
        if (first_sof_pending) begin
          check("first_sof_word", word_no, ALIGN_IDLES + 1);
          first_sof_pending = 0;
        end
        in_frame = 1; fill_cnt = 0; pay_seen = 0;
      end else if (s.k == 4'b0001 && s.data == W_EOF) begin
        exp_frames++;
        check("frame_cnt", frame_cnt, exp_frames);
        if (exp_fill >= 0) begin
          check("filler_cnt", fill_cnt, exp_fill);
          exp_fill = -1;
        end
        in_frame = 0; seen_eof = 1; idle_run = 0;
      end else begin
        pay_seen++;
      end
    end
  endtask

  task automatic drive();
    bit v;
    if (!hold) begin
      if (beat_q.size() == 0)           v = 0;
      else if (s_ready && vpat.size())  v = vpat.pop_front();
      else                              v = ($urandom_range(99) < valid_pct);
      s_valid = v;
      if (v) begin
        s_data = beat_q[0].data;
        s_last = beat_q[0].last;
      end else begin
        s_data = $urandom;
        s_last = 1'($urandom_range(1));
      end
    end
    if (s_valid && s_ready) begin
      void'(beat_q.pop_front());
      hold = 0;
    end else begin
      hold = s_valid;
    end
  endtask

  task automatic cycle();
    @(negedge tx_usr_clk);
    word_no++;
    monitor();
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((beat_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", beat_q.size() + exp_q.size(), 0);
    repeat (MIN_IFG + 2) cycle();
  endtask

  // Reset with the first beat of a ramp frame already valid, then release.
  task automatic do_reset(input int len);
    gt_reset_n = 1'b1;
    beat_q.delete(); exp_q.delete(); vpat.delete();
    hold = 0; s_valid = 0;
    exp_frames = '0; seen_eof = 0; in_frame = 0; idle_run = 0;
    exp_fill = -1; exact_gap = 0; first_sof_pending = 1; valid_pct = 100;
    repeat (2) @(negedge tx_usr_clk);
    check("rst_tx_data", tx_data, W_IDLE);
    check("rst_charisk", tx_charisk, 4'b0001);
    check("rst_ready", s_ready, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", err_overlen, 0);
    check("rst_busy", busy, 1);
    add_frame(len, 1);
    s_valid = 1; s_data = beat_q[0].data; s_last = beat_q[0].last; hold = 1;
    @(negedge tx_usr_clk);
    gt_reset_n = 1'b0;
    word_no = 1;
    monitor();
    drive();
  endtask

  initial begin
    word_no = 0;
    // 4-word ramp frame right after reset: preamble, contiguous frame, checksum 0xA
    do_reset(4);
    exp_fill = 0;
    drain(1000);

    // back-to-back frames: exactly MIN_IFG idles between them
    seen_eof = 0; exact_gap = 1;
    add_frame(3, 0);
    add_frame(5, 0);
    drain(500);
    exact_gap = 0;

    // valid pattern 1,0,0,1 inside a frame; the held first beat supplies the leading 1
    vpat.push_back(0); vpat.push_back(0); vpat.push_back(1);
    exp_fill = 2;
    add_frame(2, 1);
    drain(500);

    // truncation at MAX_LEN, then an intact frame; also a frame of exactly MAX_LEN
    add_frame(12, 1);
    add_frame(3, 0);
    drain(500);
    add_frame(MAX_LEN, 0);
    drain(500);

    // randomized frames and stalls
    for (int b = 0; b < 10; b++) begin
      valid_pct = $urandom_range(30, 100);
      for (int f = 0; f < 3; f++) add_frame($urandom_range(1, 12), 0);
      drain(3000);
    end
    valid_pct = 100;
    check("busy_after_drain", busy, 0);

    // reset asserted in the middle of DATA
    add_frame(6, 0);
    begin
      int n = 0;
      while (!(in_frame && pay_seen >= 2) && n < 200) begin
        cycle();
        n++;
      end
    end
    check("mid_frame_reached", in_frame && pay_seen >= 2, 1);
    @(posedge tx_usr_clk);
    #1;
    check("pre_reset_ready", s_ready, 1);
    #1;
    gt_reset_n = 1'b1;
    #1;
    check("mid_rst_tx_data", tx_data, W_IDLE);
    check("mid_rst_charisk", tx_charisk, 4'b0001);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_busy", busy, 1);
    do_reset(3);
    drain(1000);
    check("frame_cnt_after_rst", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
